// File: rtl/divider_scheduler_pkg.sv
// div_sched_pkg: FSM state type and sizing helpers shared by the divider scheduler
package div_sched_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} div_sched_state_t;
    function automatic int tmo_width(int timeout);
        return $clog2(timeout + 1);
    endfunction
    function automatic logic [63:0] div_zero_result(int n);
        return (64'd1 << n) - 64'd1;
    endfunction
endpackage

// File: rtl/divider_scheduler_if.sv
// divider_scheduler_if: requester and divider buses of the divider scheduler
// master: requesters + divider side; slave: the scheduler
interface divider_scheduler_if #(parameter int N = 8, parameter int NUM_REQ = 4);
    logic [NUM_REQ-1:0]        req_valid, req_ready, resp_valid;
    logic [NUM_REQ-1:0][N-1:0] req_dividend, req_divisor;
    logic [N-1:0]              resp_result, div_dividend, div_divisor, div_result;
    logic                      resp_err, div_start, div_done;
    modport master (
        output req_valid, req_dividend, req_divisor, div_result, div_done,
        input  req_ready, resp_valid, resp_result, resp_err, div_start, div_dividend, div_divisor
    );
    modport slave (
        input  req_valid, req_dividend, req_divisor, div_result, div_done,
        output req_ready, resp_valid, resp_result, resp_err, div_start, div_dividend, div_divisor
    );
endinterface

// File: rtl/divider_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first request above last_grant with wrap
// Ports: req (requests), last_grant (pointer) -> grant_onehot, grant_idx, any
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [NUM_REQ-1:0]         grant_onehot,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       any
);
    localparam int IW = $clog2(NUM_REQ);
    logic [IW-1:0] cand;
    // scan farthest offset first so the nearest request above the pointer wins
    always_comb begin
        grant_idx = '0;
        cand = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = IW'((int'(last_grant) + i) % NUM_REQ);
            if (req[cand]) grant_idx = cand;
        end
    end
    assign any = |req;
    assign grant_onehot = any ? NUM_REQ'(1) << grant_idx : '0;
endmodule

// File: rtl/divider_scheduler.sv
// divider_scheduler: round-robin sharing of one multi-cycle divider between NUM_REQ requesters
// Ports: clk, reset (sync, active-high); bus (slave): req_valid/req_dividend/req_divisor/req_ready,
// one-hot resp_valid with shared resp_result/resp_err, divider side div_start/div_dividend/div_divisor/div_result/div_done
module divider_scheduler
    import div_sched_pkg::*;
#(
    parameter int N = 8,
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64
) (
    input logic clk,
    input logic reset,
    divider_scheduler_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = tmo_width(TIMEOUT);
    localparam logic [N-1:0] DIV_ZERO_RESULT = N'(div_zero_result(N));
    div_sched_state_t state, state_next;
    logic [IW-1:0] last_grant, g, grant_idx;
    logic [NUM_REQ-1:0] grant_onehot;
    logic any, accept, zero_div, done_ok, expire, err;
    logic [N-1:0] opa, opb, res;
    logic [TW-1:0] wd;
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req(bus.req_valid),
        .last_grant(last_grant),
        .grant_onehot(grant_onehot),
        .grant_idx(grant_idx),
        .any(any)
    );
    assign accept = state == IDLE && any;
    assign zero_div = bus.req_divisor[grant_idx] == '0;
    // wd is still 0 in the first WAIT cycle, which masks a stale done
    assign done_ok = bus.div_done && wd != '0;
    assign expire = wd == TW'(TIMEOUT - 1);
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = any ? (zero_div ? RESP : ISSUE) : IDLE;
            ISSUE:   state_next = WAIT;
            WAIT:    state_next = done_ok || expire ? RESP : WAIT;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            last_grant <= IW'(NUM_REQ - 1);
            g <= '0;
            opa <= '0;
            opb <= '0;
            res <= '0;
            err <= 1'b0;
            wd <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                g <= grant_idx;
                if (zero_div) begin
                    res <= DIV_ZERO_RESULT;
                    err <= 1'b1;
                end else begin
                    opa <= bus.req_dividend[grant_idx];
                    opb <= bus.req_divisor[grant_idx];
                end
            end
            if (state == ISSUE) wd <= '0;
            if (state == WAIT) begin
                wd <= wd + 1'b1;
                if (done_ok) begin
                    res <= bus.div_result;
                    err <= 1'b0;
                end else if (expire) begin
                    res <= '0;
                    err <= 1'b1;
                end
            end
            if (state == RESP) last_grant <= g;
        end
    end
    assign bus.req_ready = state == IDLE ? grant_onehot : '0;
    assign bus.div_start = state == ISSUE;
    assign bus.resp_valid = state == RESP ? NUM_REQ'(1) << g : '0;
    assign bus.resp_result = state == RESP ? res : '0;
    assign bus.resp_err = state == RESP && err;
    assign bus.div_dividend = opa;
    assign bus.div_divisor = opb;
endmodule

// File: tb/tb_divider_scheduler.sv
// tb_divider_scheduler: randomized self-checking bench with a divider stub and a round-robin reference model
module tb_divider_scheduler;
    localparam int N = 8, NUM_REQ = 4, TIMEOUT = 8, IW = 2;
    typedef struct packed { logic [N-1:0] a; logic [N-1:0] b; } op_t;
    logic clk = 1'b0, reset = 1'b1;
    always #5 clk = ~clk;
    divider_scheduler_if #(.N(N), .NUM_REQ(NUM_REQ)) bus ();
    divider_scheduler #(.N(N), .NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0, errors = 0;
    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // divider stub: quotient after a random 2..TIMEOUT cycle latency, or never when hang is set
    logic hang = 1'b0, force_done = 1'b0, stub_busy = 1'b0;
    int force_lat = 0, stub_lat = 0, stub_cnt = 0, stub_roll = 2, cyc = 0;
    logic [N-1:0] stub_q = '0, junk = '0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        junk <= N'($urandom);
        stub_roll <= int'($urandom_range(2, TIMEOUT));
        if (reset) stub_busy <= 1'b0;
        else if (bus.div_start) begin
            stub_busy <= 1'b1;
            stub_lat <= force_lat != 0 ? force_lat : stub_roll;
            stub_cnt <= (force_lat != 0 ? force_lat : stub_roll) - 1;
            stub_q <= bus.div_divisor == '0 ? '1 : bus.div_dividend / bus.div_divisor;
        end else if (stub_busy) begin
            if (stub_cnt == 0) stub_busy <= 1'b0;
            else stub_cnt <= stub_cnt - 1;
        end
    end
    assign bus.div_done = (stub_busy && stub_cnt == 0 && !hang) || force_done;
    assign bus.div_result = bus.div_done ? stub_q : junk;

    // per-requester pending operations; the head of each queue is presented on the bus
    op_t q[NUM_REQ][$];
    task automatic enq(int r, logic [N-1:0] a, logic [N-1:0] b);
        op_t o;
        o.a = a;
        o.b = b;
        q[r].push_back(o);
    endtask
    function automatic int queued();
        int s = 0;
        for (int r = 0; r < NUM_REQ; r++) s += q[r].size();
        return s;
    endfunction
    initial begin
        bus.req_valid = '0;
        bus.req_dividend = '0;
        bus.req_divisor = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int r = 0; r < NUM_REQ; r++) begin
                bus.req_valid[r] = q[r].size() != 0;
                bus.req_dividend[r] = q[r].size() != 0 ? q[r][0].a : '0;
                bus.req_divisor[r] = q[r].size() != 0 ? q[r][0].b : '0;
            end
        end
    end

    // reference model: one op in flight, round-robin from the last responder
    function automatic int pick(logic [NUM_REQ-1:0] v, int last);
        int k;
        for (int o = 1; o <= NUM_REQ; o++) begin
            k = (last + o) % NUM_REQ;
            if (v[k[IW-1:0]]) return k;
        end
        return -1;
    endfunction
    function automatic int onehot_idx(logic [NUM_REQ-1:0] v);
        for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
        return -1;
    endfunction
    int mdl_last = NUM_REQ - 1, op_r = 0, acc_cyc = 0, start_cyc = 0, exp_g = 0, exp_cyc = 0;
    int n_ready = 0, n_start = 0, n_resp = 0;
    logic busy_m = 1'b0, started = 1'b0, op_hang = 1'b0, last_err = 1'b0, exp_err = 1'b0;
    logic [N-1:0] last_res = '0, exp_res = '0;
    op_t cur = '0;
    int grants[$];
    initial forever begin
        @(negedge clk);
        if (reset) begin
            mdl_last = NUM_REQ - 1;
            busy_m = 1'b0;
            started = 1'b0;
        end else begin
            if (bus.req_ready != '0) begin
                n_ready++;
                grants.push_back(onehot_idx(bus.req_ready));
                exp_g = pick(bus.req_valid, mdl_last);
                if (busy_m || exp_g < 0) check("ready_stray", 64'(bus.req_ready), 64'(0));
                else begin
                    check("grant", 64'(bus.req_ready), 64'(1) << exp_g);
                    if (q[exp_g].size() != 0) cur = q[exp_g].pop_front();
                    op_r = exp_g;
                    op_hang = hang;
                    acc_cyc = cyc;
                    started = 1'b0;
                    busy_m = 1'b1;
                end
            end
            if (bus.div_start) begin
                n_start++;
                if (!busy_m || started || cur.b == '0) check("start_stray", 64'(bus.div_start), 64'(0));
                else begin
                    check("start_time", 64'(cyc), 64'(acc_cyc + 1));
                    check("start_ops", 64'({bus.div_dividend, bus.div_divisor}), 64'({cur.a, cur.b}));
                    started = 1'b1;
                    start_cyc = cyc;
                end
            end
            if (bus.resp_valid != '0) begin
                n_resp++;
                last_res = bus.resp_result;
                last_err = bus.resp_err;
                if (!busy_m) check("resp_stray", 64'(bus.resp_valid), 64'(0));
                else begin
                    if (cur.b == '0) begin
                        exp_res = '1;
                        exp_err = 1'b1;
                        exp_cyc = acc_cyc + 1;
                        check("dz_nostart", 64'(started), 64'(0));
                    end else if (op_hang) begin
                        exp_res = '0;
                        exp_err = 1'b1;
                        exp_cyc = start_cyc + TIMEOUT + 1;
                    end else begin
                        exp_res = cur.a / cur.b;
                        exp_err = 1'b0;
                        exp_cyc = start_cyc + stub_lat + 1;
                    end
                    check("resp_who", 64'(bus.resp_valid), 64'(1) << op_r);
                    check("resp_result", 64'(bus.resp_result), 64'(exp_res));
                    check("resp_err", 64'(bus.resp_err), 64'(exp_err));
                    check("resp_time", 64'(cyc), 64'(exp_cyc));
                    mdl_last = op_r;
                    busy_m = 1'b0;
                end
            end else check("resp_quiet", 64'({bus.resp_result, bus.resp_err}), 64'(0));
        end
    end

    task automatic drain(int budget);
        int n = 0;
        while ((busy_m || queued() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(busy_m || queued() != 0), 64'(0));
    endtask
    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_outs", 64'({bus.req_ready, bus.resp_valid, bus.resp_result, bus.resp_err,
                               bus.div_start, bus.div_dividend, bus.div_divisor}), 64'(0));
    endtask
    task automatic random_phase(int iters);
        int burst, r;
        logic [N-1:0] a, b;
        for (int it = 0; it < iters; it++) begin
            burst = $urandom_range(1, 4);
            hang = $urandom_range(0, 15) == 0;
            for (int k = 0; k < burst; k++) begin
                r = $urandom_range(0, NUM_REQ - 1);
                a = N'($urandom);
                b = $urandom_range(0, 7) == 0 ? '0 : N'($urandom);
                enq(r, a, b);
            end
            drain(400);
        end
        hang = 1'b0;
    endtask

    int cont_exp[5] = '{0, 1, 2, 3, 0};
    int r0, s0, p0;
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end
    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_outs", 64'({bus.req_ready, bus.resp_valid, bus.resp_result, bus.resp_err,
                               bus.div_start, bus.div_dividend, bus.div_divisor}), 64'(0));
        r0 = n_ready;
        s0 = n_start;
        enq(1, 8'd100, 8'd7);
        drain(50);
        check("single_ready", 64'(n_ready - r0), 64'(1));
        check("single_start", 64'(n_start - s0), 64'(1));
        check("single_res", 64'(last_res), 64'(14));
        check("single_err", 64'(last_err), 64'(0));

        do_reset();
        grants.delete();
        enq(0, 8'd200, 8'd10);
        enq(1, 8'd9, 8'd3);
        enq(2, 8'd255, 8'd255);
        enq(3, 8'd0, 8'd5);
        enq(0, 8'd17, 8'd4);
        drain(200);
        check("cont_count", 64'(grants.size()), 64'(5));
        for (int i = 0; i < 5; i++) check("cont_grant", 64'(i < grants.size() ? grants[i] : -1), 64'(cont_exp[i]));

        s0 = n_start;
        enq(2, 8'd50, 8'd0);
        drain(50);
        check("dz_start", 64'(n_start - s0), 64'(0));
        check("dz_res", 64'(last_res), 64'(8'hFF));
        check("dz_err", 64'(last_err), 64'(1));

        hang = 1'b1;
        enq(3, 8'd123, 8'd4);
        drain(50);
        hang = 1'b0;
        check("to_res", 64'(last_res), 64'(0));
        check("to_err", 64'(last_err), 64'(1));
        enq(0, 8'd123, 8'd4);
        drain(50);
        check("after_to_res", 64'(last_res), 64'(30));
        check("after_to_err", 64'(last_err), 64'(0));

        force_lat = TIMEOUT;
        enq(1, 8'd77, 8'd7);
        drain(50);
        force_lat = 0;
        check("sim_res", 64'(last_res), 64'(11));
        check("sim_err", 64'(last_err), 64'(0));

        hang = 1'b1;
        enq(2, 8'd90, 8'd9);
        for (int n = 0; n < 20 && !started; n++) @(negedge clk);
        check("rw_started", 64'(started), 64'(1));
        p0 = n_resp;
        repeat (3) @(posedge clk);
        do_reset();
        hang = 1'b0;
        @(posedge clk);
        #1 force_done = 1'b1;
        @(negedge clk);
        check("late_done_outs", 64'({bus.resp_valid, bus.div_start, bus.req_ready}), 64'(0));
        @(posedge clk);
        #1 force_done = 1'b0;
        repeat (4) @(negedge clk);
        check("rw_no_resp", 64'(n_resp - p0), 64'(0));
        grants.delete();
        for (int r = 0; r < NUM_REQ; r++) enq(r, 8'(40 + r), 8'(r + 1));
        drain(200);
        check("post_rst_first", 64'(grants.size() > 0 ? grants[0] : -1), 64'(0));

        enq(0, 8'd0, 8'd1);
        enq(1, 8'd255, 8'd1);
        enq(2, 8'd1, 8'd255);
        enq(3, 8'd128, 8'd2);
        drain(200);
        random_phase(80);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
